calc1_core: RTL and testbench
=============================

Name: calc1_core

Overview:
- Four-port integer calculator serving four independent requesters.
- Each port issues one command at a time (add, subtract, shift left, shift right) with two 32-bit operands over two consecutive cycles.
- Commands on the four ports share one add/sub unit and one shifter through a fixed-priority arbiter.
- Each result returns on that port's own data/response outputs.

Parameters:
- DATA_W, 32, operand/result width; bus bits numbered [0:DATA_W-1], bit 0 = MSB.
- SHAMT_W, 5, number of operand-2 LSBs used as the shift amount.

Ports:
- c_clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on c_clk.
- reqN_cmd_in (N=1..4)  in  4  command: 0 nop, 1 add, 2 sub, 5 shl, 6 shr; others invalid.
- reqN_data_in (N=1..4)  in  DATA_W  operand 1 in the command cycle, operand 2 in the next cycle.
- out_dataN (N=1..4)  out  DATA_W  result; valid only while out_respN != 0, otherwise 0.
- out_respN (N=1..4)  out  2  0 none, 1 success, 2 overflow/underflow/invalid command, 3 reserved (never driven).

Behaviour:
- Reset: while reset=1, all out_dataN=0, all out_respN=0, all port FSMs IDLE and arbiter pointers cleared. In-flight commands are discarded and produce no response. First command is accepted on the first edge with reset=0.
- Port FSM states:
  - IDLE: a non-zero cmd latches cmd and operand 1, then goes to OP2. Cmd 0 stays IDLE.
  - OP2: latches operand 2 unconditionally, then goes to PEND.
  - PEND: waits for an arbiter grant, then goes to RESP.
  - RESP: drives the response for exactly one cycle, then goes to IDLE.
- One outstanding command per port. Cmd input in OP2/PEND/RESP is ignored. A new command is accepted in the cycle after the response cycle.
- Arbitration:
  - Add/sub unit and shifter arbitrate independently.
  - Fixed priority port1 > port2 > port3 > port4.
  - One grant per unit per cycle, so an add and a shift can complete in the same cycle.
  - Invalid commands need no unit; they go from PEND to RESP on the next cycle.
- Latency: command cycle T, operand 2 at T+1, earliest response at T+3. Each priority loss adds one cycle.
- Arithmetic (all unsigned):
  - add: result = op1+op2. If there is a carry out of bit 0, resp=2 and data=0.
  - sub: result = op1-op2. If op2>op1 (underflow), resp=2 and data=0. op1==op2 gives resp=1, data=0.
  - shl/shr: logical shift of op1 by op2 LSBs [DATA_W-SHAMT_W:DATA_W-1]; upper op2 bits ignored. Zero-fill. Shift by 0 returns op1. resp=1 always.
  - Invalid cmd (3,4,7-15): resp=2, data=0.
- Outputs are registered. out_respN/out_dataN are non-zero for exactly one cycle per command.

Optional Feature:
- Macro: CALC1_CORE_SHIFT_OVF_EN.
- Defined: shl reports resp=2 and data=0 if any 1-bit is shifted out of bit 0.
- Undefined: shifted-out bits are silently dropped and resp=1.

Decomposition:
- Package calc1_pkg holds:
  - cmd encodings CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6;
  - resp encodings RESP_NONE=0, RESP_OK=1, RESP_ERR=2;
  - port FSM state typedef.
- Sub-module calc1_port_ctrl, instantiated four times: per-port FSM, operand latches, request/grant interface, output register.
- Top level holds the two arbiters, the add/sub unit and the shifter.

Test Plan:
- Single add on port 1: cmd=1, op1=0x0000_0005, op2=0x0000_0003 -> at T+3 out_resp1=1, out_data1=0x0000_0008; ports 2-4 resp=0.
- Add overflow on port 2: op1=0xFFFF_FFFF, op2=1 -> out_resp2=2, out_data2=0. Sub underflow: op1=3, op2=5 -> resp=2.
- Shifts on port 3:
  - shl op1=0x0000_0001, op2=0x0000_0004 -> resp=1, data=0x0000_0010.
  - shr op1=0x8000_0000, op2=0x0000_001F -> data=0x0000_0001.
  - op2=0xFFFF_FFE0 (shamt 0) -> data=op1.
- Contention: ports 1-4 each issue add op1=N, op2=N on the same cycle -> port1 responds at T+3, port2 T+4, port3 T+5, port4 T+6, data=2N each.
- Mixed concurrency: port1 add + port2 shl on the same cycle -> both respond at T+3. Invalid cmd=4 on port 4 -> resp=2 at T+3.
- Reset mid-operation: issue an add, assert reset at T+1 for 2 cycles -> no response ever appears. A new add issued after reset completes normally.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1_pkg: shared command/response encodings, port FSM state type and
// small command-classification helpers for the calc1_core calculator.
package calc1_pkg;

  localparam int NPORT = 4;

  // Command encodings
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  // Response encodings (3 is reserved and never produced)
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_PEND = 2'd2,
    ST_RESP = 2'd3
  } port_state_t;

  function automatic logic is_addsub(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB);
  endfunction

  function automatic logic is_shift(input logic [3:0] c);
    return (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

  function automatic logic is_valid_cmd(input logic [3:0] c);
    return is_addsub(c) || is_shift(c);
  endfunction

endpackage

// File: rtl/calc1_port_ctrl.sv
// calc1_port_ctrl: one requester port. Captures command + operand 1, then
// operand 2, waits for a unit grant (or self-completes an invalid command),
// and presents the result for exactly one cycle from registered outputs.
// Handshake: the top sees a request whenever state_o == ST_PEND; gnt is
// asserted for a single cycle and is consumed on that edge (no back-pressure
// from the port side; res_data/res_resp are valid in the grant cycle only).
module calc1_port_ctrl
  import calc1_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd_in,
  input  logic [0:DATA_W-1] data_in,
  input  logic              gnt,
  input  logic [0:DATA_W-1] res_data,
  input  logic [1:0]        res_resp,
  output logic [3:0]        cmd_o,
  output logic [0:DATA_W-1] op1_o,
  output logic [0:DATA_W-1] op2_o,
  output logic [0:DATA_W-1] out_data,
  output logic [1:0]        out_resp,
  output port_state_t       state_o
);

  port_state_t       state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [0:DATA_W-1] op1_q, op1_d;
  logic [0:DATA_W-1] op2_q, op2_d;
  logic [0:DATA_W-1] out_data_q, out_data_d;
  logic [1:0]        out_resp_q, out_resp_d;

  // Next-state, operand capture and output-register load
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    out_data_d = '0;
    out_resp_d = RESP_NONE;
    case (state_q)
      ST_IDLE: begin
        if (cmd_in != CMD_NOP) begin
          cmd_d   = cmd_in;
          op1_d   = data_in;
          state_d = ST_OP2;
        end
      end
      ST_OP2: begin
        op2_d   = data_in;
        state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!is_valid_cmd(cmd_q)) begin
          out_resp_d = RESP_ERR;
          state_d    = ST_RESP;
        end else if (gnt) begin
          out_data_d = res_data;
          out_resp_d = res_resp;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_NOP;
      op1_q      <= '0;
      op2_q      <= '0;
      out_data_q <= '0;
      out_resp_q <= RESP_NONE;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      out_data_q <= out_data_d;
      out_resp_q <= out_resp_d;
    end
  end

  assign cmd_o    = cmd_q;
  assign op1_o    = op1_q;
  assign op2_o    = op2_q;
  assign out_data = out_data_q;
  assign out_resp = out_resp_q;
  assign state_o  = state_q;

endmodule

// File: rtl/calc1_core.sv
// calc1_core: four-port integer calculator. Four port controllers share one
// add/sub unit and one shifter; each unit has its own fixed-priority arbiter
// (port1 highest). Buses use [0:DATA_W-1] numbering, bit 0 = MSB.
// Optional macro CALC1_CORE_SHIFT_OVF_EN: shl reports an error when any
// 1-bit is shifted out past bit 0; otherwise those bits are dropped.
module calc1_core
  import calc1_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:DATA_W-1] out_data1,
  output logic [1:0]        out_resp1,
  output logic [0:DATA_W-1] out_data2,
  output logic [1:0]        out_resp2,
  output logic [0:DATA_W-1] out_data3,
  output logic [1:0]        out_resp3,
  output logic [0:DATA_W-1] out_data4,
  output logic [1:0]        out_resp4
);

  logic [3:0]        cmd_in_a   [NPORT];
  logic [0:DATA_W-1] data_in_a  [NPORT];
  logic [3:0]        cmd_a      [NPORT];
  logic [0:DATA_W-1] op1_a      [NPORT];
  logic [0:DATA_W-1] op2_a      [NPORT];
  logic [0:DATA_W-1] res_data_a [NPORT];
  logic [1:0]        res_resp_a [NPORT];
  logic [0:DATA_W-1] out_data_a [NPORT];
  logic [1:0]        out_resp_a [NPORT];
  port_state_t       port_state [NPORT];

  logic [NPORT-1:0] add_req, shf_req, add_gnt, shf_gnt, gnt_a;

  logic [3:0]         add_cmd, shf_cmd;
  logic [0:DATA_W-1]  add_op1, add_op2, shf_op1;
  logic [SHAMT_W-1:0] shf_amt;
  logic [DATA_W:0]    add_sum;
  logic [0:DATA_W-1]  add_data, shf_data;
  logic [1:0]         add_resp, shf_resp;
`ifdef CALC1_CORE_SHIFT_OVF_EN
  logic [2*DATA_W-1:0] shf_wide;
`endif

  assign cmd_in_a[0]  = req1_cmd_in;
  assign cmd_in_a[1]  = req2_cmd_in;
  assign cmd_in_a[2]  = req3_cmd_in;
  assign cmd_in_a[3]  = req4_cmd_in;
  assign data_in_a[0] = req1_data_in;
  assign data_in_a[1] = req2_data_in;
  assign data_in_a[2] = req3_data_in;
  assign data_in_a[3] = req4_data_in;

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    assign add_req[g]    = (port_state[g] == ST_PEND) && is_addsub(cmd_a[g]);
    assign shf_req[g]    = (port_state[g] == ST_PEND) && is_shift(cmd_a[g]);
    assign gnt_a[g]      = add_gnt[g] | shf_gnt[g];
    assign res_data_a[g] = add_gnt[g] ? add_data : shf_data;
    assign res_resp_a[g] = add_gnt[g] ? add_resp : shf_resp;

    calc1_port_ctrl #(.DATA_W(DATA_W)) u_port (
      .clk      (c_clk),
      .reset    (reset),
      .cmd_in   (cmd_in_a[g]),
      .data_in  (data_in_a[g]),
      .gnt      (gnt_a[g]),
      .res_data (res_data_a[g]),
      .res_resp (res_resp_a[g]),
      .cmd_o    (cmd_a[g]),
      .op1_o    (op1_a[g]),
      .op2_o    (op2_a[g]),
      .out_data (out_data_a[g]),
      .out_resp (out_resp_a[g]),
      .state_o  (port_state[g])
    );
  end

  // Fixed-priority arbiters (lowest index wins) and one-hot operand muxes
  always_comb begin
    add_gnt = '0;
    shf_gnt = '0;
    add_cmd = CMD_NOP;
    add_op1 = '0;
    add_op2 = '0;
    shf_cmd = CMD_NOP;
    shf_op1 = '0;
    shf_amt = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (add_req[i] && (add_gnt == '0)) begin
        add_gnt[i] = 1'b1;
        add_cmd    = cmd_a[i];
        add_op1    = op1_a[i];
        add_op2    = op2_a[i];
      end
      if (shf_req[i] && (shf_gnt == '0)) begin
        shf_gnt[i] = 1'b1;
        shf_cmd    = cmd_a[i];
        shf_op1    = op1_a[i];
        shf_amt    = op2_a[i][DATA_W-SHAMT_W:DATA_W-1];
      end
    end
  end

  // Unsigned add/sub with carry-out and underflow detection
  always_comb begin
    add_sum  = {1'b0, add_op1} + {1'b0, add_op2};
    add_data = '0;
    add_resp = RESP_OK;
    if (add_cmd == CMD_SUB) begin
      if (add_op2 > add_op1) add_resp = RESP_ERR;
      else                   add_data = add_op1 - add_op2;
    end else begin
      if (add_sum[DATA_W]) add_resp = RESP_ERR;
      else                 add_data = add_sum[DATA_W-1:0];
    end
  end

  // Logical shifter; optional overflow check on shl
  always_comb begin
    shf_resp = RESP_OK;
    if (shf_cmd == CMD_SHL) shf_data = shf_op1 << shf_amt;
    else                    shf_data = shf_op1 >> shf_amt;
`ifdef CALC1_CORE_SHIFT_OVF_EN
    shf_wide = {{DATA_W{1'b0}}, shf_op1} << shf_amt;
    if ((shf_cmd == CMD_SHL) && (|shf_wide[2*DATA_W-1:DATA_W])) begin
      shf_resp = RESP_ERR;
      shf_data = '0;
    end
`endif
  end

  assign out_data1 = out_data_a[0];
  assign out_resp1 = out_resp_a[0];
  assign out_data2 = out_data_a[1];
  assign out_resp2 = out_resp_a[1];
  assign out_data3 = out_data_a[2];
  assign out_resp3 = out_resp_a[2];
  assign out_data4 = out_data_a[3];
  assign out_resp4 = out_resp_a[3];

endmodule

// File: tb/tb_calc1_core.sv
// tb_calc1_core: directed bench for calc1_core. A behavioural model computes
// each command's {resp, data}; the expected response cycle is hand-derived
// per vector. A compare process checks all four ports every cycle.
module tb_calc1_core;
  import calc1_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic c_clk = 1'b0;
  logic reset = 1'b1;
  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [3:0]   cmd_a  [4];
  logic [W-1:0] data_a [4];
  logic [W-1:0] od     [4];
  logic [1:0]   orsp   [4];

  calc1_core dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_a[0]),
    .req1_data_in (data_a[0]),
    .req2_cmd_in  (cmd_a[1]),
    .req2_data_in (data_a[1]),
    .req3_cmd_in  (cmd_a[2]),
    .req3_data_in (data_a[2]),
    .req4_cmd_in  (cmd_a[3]),
    .req4_data_in (data_a[3]),
    .out_data1    (od[0]),
    .out_resp1    (orsp[0]),
    .out_data2    (od[1]),
    .out_resp2    (orsp[1]),
    .out_data3    (od[2]),
    .out_resp3    (orsp[2]),
    .out_data4    (od[3]),
    .out_resp4    (orsp[3])
  );

  // ---------------- scoreboard ----------------
  // entry = {response cycle[31:0], resp[1:0], data[31:0]}
  logic [65:0]  exp_q [4][$];
  logic [W-1:0] op2_pend [4];
  logic         op2_val  [4];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: returns {resp, data}
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [63:0] wide;
    logic [4:0]  amt;
    amt = b[4:0];
    case (c)
      CMD_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        if (s[32]) return {RESP_ERR, 32'd0};
        return {RESP_OK, s[31:0]};
      end
      CMD_SUB: begin
        if (b > a) return {RESP_ERR, 32'd0};
        return {RESP_OK, a - b};
      end
      CMD_SHL: begin
        wide = {32'd0, a} << amt;
`ifdef CALC1_CORE_SHIFT_OVF_EN
        if (wide[63:32] != 32'd0) return {RESP_ERR, 32'd0};
`endif
        return {RESP_OK, wide[31:0]};
      end
      CMD_SHR: return {RESP_OK, a >> amt};
      default: return {RESP_ERR, 32'd0};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input bit expect_resp);
    logic [33:0] r;
    cmd_a[p]    = c;
    data_a[p]   = a;
    op2_pend[p] = b;
    op2_val[p]  = 1'b1;
    if (expect_resp) begin
      r = model(c, a, b);
      exp_q[p].push_back({32'(cyc + lat), r});
    end
  endtask

  // Advance one cycle; operand 2 goes out with a junk cmd that must be ignored
  task automatic step();
    @(posedge c_clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (op2_val[p]) begin
        data_a[p]  = op2_pend[p];
        cmd_a[p]   = 4'hF;
        op2_val[p] = 1'b0;
      end else begin
        cmd_a[p]  = CMD_NOP;
        data_a[p] = $urandom;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- compare process ----------------
  always @(negedge c_clk) begin
    if (cyc > 0) begin
      for (int p = 0; p < 4; p++) begin
        if (exp_q[p].size() > 0 && exp_q[p][0][65:34] == 32'(cyc)) begin
          logic [65:0] e;
          e = exp_q[p].pop_front();
          check($sformatf("port%0d resp", p + 1), 64'(orsp[p]), 64'(e[33:32]));
          check($sformatf("port%0d data", p + 1), 64'(od[p]), 64'(e[31:0]));
        end else begin
          check($sformatf("port%0d idle resp", p + 1), 64'(orsp[p]), 64'd0);
          check($sformatf("port%0d idle data", p + 1), 64'(od[p]), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]    = CMD_NOP;
      data_a[p]   = '0;
      op2_pend[p] = '0;
      op2_val[p]  = 1'b0;
    end

    // Hand-computed pins on the model itself
    check("model add 5+3", 64'(model(CMD_ADD, 32'd5, 32'd3)), 64'({RESP_OK, 32'd8}));
    check("model add ovf", 64'(model(CMD_ADD, 32'hFFFF_FFFF, 32'd1)), 64'({RESP_ERR, 32'd0}));
    check("model sub udf", 64'(model(CMD_SUB, 32'd3, 32'd5)), 64'({RESP_ERR, 32'd0}));
    check("model shr 31", 64'(model(CMD_SHR, 32'h8000_0000, 32'h1F)), 64'({RESP_OK, 32'd1}));
    check("model shl 4", 64'(model(CMD_SHL, 32'd1, 32'd4)), 64'({RESP_OK, 32'h10}));
    check("model invalid", 64'(model(4'd4, 32'd1, 32'd1)), 64'({RESP_ERR, 32'd0}));

    // Reset held for three edges, then released
    steps(3);
    reset = 1'b0;

    // Single add on port 1
    issue(0, CMD_ADD, 32'd5, 32'd3, 3, 1'b1);
    steps(6);

    // Add overflow then sub underflow on port 2
    issue(1, CMD_ADD, 32'hFFFF_FFFF, 32'd1, 3, 1'b1);
    steps(5);
    issue(1, CMD_SUB, 32'd3, 32'd5, 3, 1'b1);
    steps(5);

    // Shifts on port 3
    issue(2, CMD_SHL, 32'd1, 32'd4, 3, 1'b1);
    steps(5);
    issue(2, CMD_SHR, 32'h8000_0000, 32'h1F, 3, 1'b1);
    steps(5);
    issue(2, CMD_SHL, 32'h1234_5678, 32'hFFFF_FFE0, 3, 1'b1);
    steps(5);
    issue(2, CMD_SHL, 32'h8000_0000, 32'd1, 3, 1'b1);
    steps(5);

    // Contention on the add unit: one extra cycle per priority loss
    for (int p = 0; p < 4; p++) issue(p, CMD_ADD, 32'(p + 1), 32'(p + 1), 3 + p, 1'b1);
    steps(9);

    // Mixed: add + shl complete together; sub waits behind port1; invalid on port 4
    issue(0, CMD_ADD, 32'd10, 32'd20, 3, 1'b1);
    issue(1, CMD_SHL, 32'hF000_0001, 32'd4, 3, 1'b1);
    issue(2, CMD_SUB, 32'd7, 32'd7, 4, 1'b1);
    issue(3, 4'd4, 32'hDEAD_BEEF, 32'd1, 3, 1'b1);
    steps(8);

    // Shifter contention: port1 shr beats port3 shl
    issue(0, CMD_SHR, 32'hF0F0_0000, 32'd8, 3, 1'b1);
    issue(2, CMD_SHL, 32'h0000_00FF, 32'd8, 4, 1'b1);
    steps(8);

    // Back-to-back on port 1: next command accepted right after the response cycle
    issue(0, CMD_ADD, 32'd1, 32'd1, 3, 1'b1);
    steps(4);
    issue(0, CMD_SUB, 32'd9, 32'd4, 3, 1'b1);
    steps(6);

    // Reset mid-operation: command is discarded, then a fresh add completes
    issue(0, CMD_ADD, 32'd1, 32'd2, 0, 1'b0);
    step();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(6);
    issue(0, CMD_ADD, 32'd100, 32'd200, 3, 1'b1);
    steps(8);

    // Any entry still queued never appeared
    for (int p = 0; p < 4; p++)
      check($sformatf("port%0d missing responses", p + 1), 64'(exp_q[p].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
